// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - EX-stage combinational ALU plus multi-cycle multiply/divide unit with HI/LO
module alu_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUop,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    input  logic [2:0]       MDop,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [SHW-1:0] shamt;
    logic [WIDTH:0] add_ext;
    logic [WIDTH:0] sub_ext;

    assign shamt   = A[SHW-1:0];
    // One extra sign bit so signed overflow shows up as a mismatch of the top two bits
    assign add_ext = {A[WIDTH-1], A} + {B[WIDTH-1], B};
    assign sub_ext = {A[WIDTH-1], A} - {B[WIDTH-1], B};

    // ALU result and overflow, fully assigned for every opcode
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (ALUop)
            4'd0:  result = A & B;
            4'd1:  result = A | B;
            4'd2: begin
                result   = add_ext[WIDTH-1:0];
                overflow = add_ext[WIDTH] ^ add_ext[WIDTH-1];
            end
            4'd3: begin
                result   = sub_ext[WIDTH-1:0];
                overflow = sub_ext[WIDTH] ^ sub_ext[WIDTH-1];
            end
            4'd4:  result = A ^ B;
            4'd5:  result = ~(A | B);
            4'd6:  result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'd7:  result = {{(WIDTH-1){1'b0}}, (A < B)};
            4'd8:  result = B << shamt;
            4'd9:  result = B >> shamt;
            4'd10: result = $signed(B) >>> shamt;
            4'd11: result = B << (WIDTH / 2);
            default: result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // MDU
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic             op_signed_q;

    logic [WIDTH-1:0]          hi_d, lo_d;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic                      min_neg1;
    logic [WIDTH-1:0]          div_b_u, div_b_s;
    logic signed [WIDTH-1:0]   div_qs, div_rs;
    logic [WIDTH-1:0]          div_qu, div_ru;

    assign prod_s = $signed({{WIDTH{op_a_q[WIDTH-1]}}, op_a_q}) *
                    $signed({{WIDTH{op_b_q[WIDTH-1]}}, op_b_q});
    assign prod_u = {{WIDTH{1'b0}}, op_a_q} * {{WIDTH{1'b0}}, op_b_q};

    // The special divisor cases are resolved explicitly below, so the raw
    // dividers only ever see a safe divisor (no divide by zero, no MIN/-1).
    assign min_neg1 = (op_a_q == SMIN) && (op_b_q == '1);
    assign div_b_u  = (op_b_q == '0) ? ONE : op_b_q;
    assign div_b_s  = ((op_b_q == '0) || min_neg1) ? ONE : op_b_q;
    assign div_qs   = $signed(op_a_q) / $signed(div_b_s);
    assign div_rs   = $signed(op_a_q) % $signed(div_b_s);
    assign div_qu   = op_a_q / div_b_u;
    assign div_ru   = op_a_q % div_b_u;

    // HI/LO values to be written on the final edge of the running operation
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == S_MUL) begin
            if (op_signed_q) {hi_d, lo_d} = prod_s;
            else             {hi_d, lo_d} = prod_u;
        end else if (state_q == S_DIV) begin
            if (op_b_q == '0) begin
                lo_d = '1;
                hi_d = op_a_q;
            end else if (op_signed_q && min_neg1) begin
                lo_d = SMIN;
                hi_d = '0;
            end else if (op_signed_q) begin
                lo_d = div_qs;
                hi_d = div_rs;
            end else begin
                lo_d = div_qu;
                hi_d = div_ru;
            end
        end
    end

    // MDU control FSM: accept requests in IDLE, count down, commit HI/LO on the last edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_signed_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (MDop)
                            3'd1, 3'd2: begin
                                op_a_q      <= A;
                                op_b_q      <= B;
                                op_signed_q <= (MDop == 3'd1);
                                cnt_q       <= CW'(MUL_CYCLES - 1);
                                busy_q      <= 1'b1;
                                state_q     <= S_MUL;
                            end
                            3'd3, 3'd4: begin
                                op_a_q      <= A;
                                op_b_q      <= B;
                                op_signed_q <= (MDop == 3'd3);
                                cnt_q       <= CW'(DIV_CYCLES - 1);
                                busy_q      <= 1'b1;
                                state_q     <= S_DIV;
                            end
                            3'd5:    hi_q <= A;
                            3'd6:    lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (cnt_q == '0) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - directed self-checking bench for alu_mdu
module tb_alu_mdu;

    logic        clk;
    logic        rst_n;
    logic [31:0] A, B, result, HI, LO;
    logic [3:0]  ALUop;
    logic        overflow, start, busy;
    logic [2:0]  MDop;

    logic [15:0] A16, B16, result16, HI16, LO16;
    logic [3:0]  ALUop16;
    logic        overflow16, start16, busy16;
    logic [2:0]  MDop16;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .ALUop(ALUop),
        .result(result), .overflow(overflow), .MDop(MDop), .start(start),
        .busy(busy), .HI(HI), .LO(LO)
    );

    alu_mdu #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut16 (
        .clk(clk), .rst_n(rst_n), .A(A16), .B(B16), .ALUop(ALUop16),
        .result(result16), .overflow(overflow16), .MDop(MDop16), .start(start16),
        .busy(busy16), .HI(HI16), .LO(LO16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one MDU request (caller sits between a falling and rising edge),
    // scramble the operand inputs after capture, and count busy cycles.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        A = a; B = b; MDop = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDop = 3'd0; A = ~a; B = ~b;
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        A = '0; B = '0; ALUop = '0; MDop = '0; start = 1'b0;
        A16 = '0; B16 = '0; ALUop16 = '0; MDop16 = '0; start16 = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, HI, LO} !== 65'd0) begin
            n_fail++;
            $display("FAIL reset32: busy=%b HI=%h LO=%h required 0/0/0", busy, HI, LO);
        end
        n_checks++;
        if ({busy16, HI16, LO16} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset16: busy=%b HI=%h LO=%h required 0/0/0", busy16, HI16, LO16);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        ov;
    } alu_vec_t;

    task automatic test_alu;
        alu_vec_t tab[16];
        tab = '{
            '{4'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1},
            '{4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
            '{4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0},
            '{4'd10, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0},
            '{4'd13, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0},
            '{4'd3,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1},
            '{4'd3,  32'h00000005, 32'h00000003, 32'h00000002, 1'b0},
            '{4'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
            '{4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0},
            '{4'd1,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0},
            '{4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0},
            '{4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0},
            '{4'd8,  32'h00000024, 32'h00000001, 32'h00000010, 1'b0},
            '{4'd9,  32'h00000004, 32'h80000000, 32'h08000000, 1'b0},
            '{4'd11, 32'h00000000, 32'h00001234, 32'h12340000, 1'b0},
            '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0}
        };
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ALUop = tab[i].op; A = tab[i].a; B = tab[i].b;
            #1;
            n_checks++;
            if (result !== tab[i].r || overflow !== tab[i].ov) begin
                n_fail++;
                $display("FAIL alu[%0d] op=%0d: result=%h ov=%b required %h ov=%b",
                         i, tab[i].op, result, overflow, tab[i].r, tab[i].ov);
            end
        end
    endtask

    task automatic test_mul;
        int c;
        run_md(3'd1, 32'hFFFFFFFE, 32'd3, c);
        n_checks++;
        if (c != 5 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
            n_fail++;
            $display("FAIL mult: busy=%0d HI=%h LO=%h required 5 FFFFFFFF FFFFFFFA", c, HI, LO);
        end
        run_md(3'd2, 32'hFFFFFFFE, 32'd3, c);
        n_checks++;
        if (c != 5 || HI !== 32'h00000002 || LO !== 32'hFFFFFFFA) begin
            n_fail++;
            $display("FAIL multu: busy=%0d HI=%h LO=%h required 5 00000002 FFFFFFFA", c, HI, LO);
        end
    endtask

    task automatic test_div;
        int c;
        run_md(3'd3, 32'hFFFFFFF9, 32'd2, c);
        n_checks++;
        if (c != 10 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
            n_fail++;
            $display("FAIL div_neg: busy=%0d HI=%h LO=%h required 10 FFFFFFFF FFFFFFFD", c, HI, LO);
        end
        run_md(3'd4, 32'd7, 32'd0, c);
        n_checks++;
        if (c != 10 || HI !== 32'd7 || LO !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL divu_zero: busy=%0d HI=%h LO=%h required 10 00000007 FFFFFFFF", c, HI, LO);
        end
        run_md(3'd3, 32'h80000000, 32'hFFFFFFFF, c);
        n_checks++;
        if (c != 10 || HI !== 32'd0 || LO !== 32'h80000000) begin
            n_fail++;
            $display("FAIL div_min: busy=%0d HI=%h LO=%h required 10 00000000 80000000", c, HI, LO);
        end
        run_md(3'd3, 32'hFFFFFFFB, 32'd0, c);
        n_checks++;
        if (HI !== 32'hFFFFFFFB || LO !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL div_zero_s: HI=%h LO=%h required FFFFFFFB FFFFFFFF", HI, LO);
        end
    endtask

    task automatic test_interlock;
        int c;
        A = 32'd100; B = 32'd7; MDop = 3'd3; start = 1'b1;
        @(negedge clk);
        A = 32'h1234; MDop = 3'd5;
        @(negedge clk);
        A = 32'd3; B = 32'd3; MDop = 3'd1;
        @(negedge clk);
        start = 1'b0; MDop = 3'd0;
        c = 2;
        while (busy === 1'b1 && c < 200) begin
            c++;
            @(negedge clk);
        end
        n_checks++;
        if (c != 10 || HI !== 32'd2 || LO !== 32'd14) begin
            n_fail++;
            $display("FAIL interlock: busy=%0d HI=%h LO=%h required 10 00000002 0000000E", c, HI, LO);
        end
        A = 32'h55; MDop = 3'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDop = 3'd0;
        n_checks++;
        if (LO !== 32'h55 || HI !== 32'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mtlo: LO=%h HI=%h busy=%b required 00000055 00000002 0", LO, HI, busy);
        end
    endtask

    task automatic test_back_to_back;
        int c;
        run_md(3'd2, 32'd5, 32'd6, c);
        n_checks++;
        if (c != 5 || HI !== 32'd0 || LO !== 32'd30) begin
            n_fail++;
            $display("FAIL b2b_first: busy=%0d HI=%h LO=%h required 5 00000000 0000001E", c, HI, LO);
        end
        run_md(3'd4, 32'd30, 32'd4, c);
        n_checks++;
        if (c != 10 || HI !== 32'd2 || LO !== 32'd7) begin
            n_fail++;
            $display("FAIL b2b_second: busy=%0d HI=%h LO=%h required 10 00000002 00000007", c, HI, LO);
        end
    endtask

    task automatic test_reset_mid;
        int c;
        A = 32'd9; B = 32'd9; MDop = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDop = 3'd0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: busy=%b required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, HI, LO} !== 65'd0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b HI=%h LO=%h required 0/0/0", busy, HI, LO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_md(3'd1, 32'd6, 32'd7, c);
        n_checks++;
        if (c != 5 || HI !== 32'd0 || LO !== 32'd42) begin
            n_fail++;
            $display("FAIL post_reset_mult: busy=%0d HI=%h LO=%h required 5 00000000 0000002A", c, HI, LO);
        end
    endtask

    task automatic test_width16;
        int c;
        ALUop16 = 4'd8; A16 = 16'h0013; B16 = 16'h0001;
        #1;
        n_checks++;
        if (result16 !== 16'h0008) begin
            n_fail++;
            $display("FAIL sll16: result=%h required 0008", result16);
        end
        A16 = 16'h7FFF; B16 = 16'h7FFF; MDop16 = 3'd1; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0; MDop16 = 3'd0;
        c = 0;
        while (busy16 === 1'b1 && c < 200) begin
            c++;
            @(negedge clk);
        end
        n_checks++;
        if (c != 1 || HI16 !== 16'h3FFF || LO16 !== 16'h0001) begin
            n_fail++;
            $display("FAIL mult16: busy=%0d HI=%h LO=%h required 1 3FFF 0001", c, HI16, LO16);
        end
        A16 = 16'd100; B16 = 16'd7; MDop16 = 3'd4; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0; MDop16 = 3'd0;
        c = 0;
        while (busy16 === 1'b1 && c < 200) begin
            c++;
            @(negedge clk);
        end
        n_checks++;
        if (c != 3 || HI16 !== 16'd2 || LO16 !== 16'd14) begin
            n_fail++;
            $display("FAIL divu16: busy=%0d HI=%h LO=%h required 3 0002 000E", c, HI16, LO16);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_div();
        test_interlock();
        test_back_to_back();
        test_reset_mid();
        test_width16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
